// File: rtl/shift_add_mult.sv
// Sequential shift-and-add multiplier with early termination on a zero multiplier.
// Optional macro SHIFT_ADD_MULT_SIGNED_EN selects two's-complement operands.
module shift_add_mult #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    acc, mcand, result;
  logic [WIDTH-1:0] mplier, a_mag, b_mag;
  logic             load, step, finish;

`ifdef SHIFT_ADD_MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Magnitudes as WIDTH-bit unsigned so the most negative value maps to 2^(WIDTH-1)
  always_comb begin
    a_mag  = a_in[WIDTH-1] ? -a_in : a_in;
    b_mag  = b_in[WIDTH-1] ? -b_in : b_in;
    sign_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
    result = sign_q ? -acc : acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sign_q <= 1'b0;
    else if (load) sign_q <= sign_d;
  end
`else
  always_comb begin
    a_mag  = a_in;
    b_mag  = b_in;
    result = acc;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (mplier != '0) begin
          step = 1'b1;
        end else begin
          finish    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, add/shift iteration, product load on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else begin
      if (load) begin
        acc    <= '0;
        mcand  <= PW'(a_mag);
        mplier <= b_mag;
      end else if (step) begin
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (finish) product <= result;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
